// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: data width, forwarding select codes,
// and the per-stage stall/flush control bundle.
package mips_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2,
    FWD_IMM   = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/mux_n.sv
// Combinational NUM_IN:1 selector with out-of-range select indicator.
// Ports: sel, data_in (packed, input k at [k*WIDTH +: WIDTH]), data_out, oor.
module mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]        data_out,
  output logic                    oor
);

  localparam logic [SEL_W:0] LIMIT = (SEL_W+1)'(NUM_IN);

  // Loop compare keeps every index in range; unmatched sel gives zero.
  always_comb begin
    data_out = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data_out = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  assign oor = ({1'b0, sel} >= LIMIT);

endmodule

// File: rtl/pipe_mux_reg.sv
// N-input selector with pipeline register, stall/flush, valid, sticky sel_err.
// Ports: clk, rst, stall, flush, in_valid, sel, data_in -> Out, out_valid, sel_err.
module pipe_mux_reg
  import mips_pkg::*;
#(
  parameter int                 WIDTH     = DATA_W,
  parameter int                 NUM_IN    = 4,
  localparam int                SEL_W     = $clog2(NUM_IN),
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]        Out,
  output logic                    out_valid,
  output logic                    sel_err
);

  stage_ctrl_t      ctrl;
  logic [WIDTH-1:0] mux_out;
  logic             mux_oor;

  logic [WIDTH-1:0] out_d, out_q;
  logic             valid_d, valid_q;
  logic             err_d, err_q;

  assign ctrl = '{stall: stall, flush: flush};

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .sel      (sel),
    .data_in  (data_in),
    .data_out (mux_out),
    .oor      (mux_oor)
  );

  // flush > stall > load; rst is applied in the register itself.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (ctrl.flush) begin
      out_d   = RESET_VAL;
      valid_d = 1'b0;
    end else if (!ctrl.stall) begin
      if (mux_oor) begin
        out_d   = RESET_VAL;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end else begin
        out_d   = mux_out;
        valid_d = in_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= RESET_VAL;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign Out       = out_q;
  assign out_valid = valid_q;
  assign sel_err   = err_q;

endmodule
